arac_hareket_hakem: RTL
=======================

Name: arac_hareket_hakem

Overview:
- Clocked arbiter that schedules movement permission for two vehicles sharing one lane. Vehicle 1 is in front, vehicle 2 is behind.
- Each vehicle presents a move request and its 2-bit direction {solbit, sagbit}.
- The block detects colliding direction pairs and serialises the two vehicles when they collide; otherwise it grants both at once.
- It sits between the per-vehicle direction logic and the vehicle drive enables. It adds round-robin fairness and starvation flags.

Parameters:
HAREKET_CYC, 4, length of one grant window in clocks (>=1)
ARA_CYC, 1, guard gap in clocks after each window with no grants (>=0)
MAX_BEKLE, 8, consecutive wait cycles at which the starvation flag asserts (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
istek1  in  1  vehicle 1 move request (level)
istek2  in  1  vehicle 2 move request (level)
yon1  in  2  vehicle 1 direction {solbit, sagbit}
yon2  in  2  vehicle 2 direction {solbit, sagbit}
izin1  out  1  vehicle 1 move grant
izin2  out  1  vehicle 2 move grant
carpisma_engellendi  out  1  one-cycle pulse: a conflict was serialised
aclik1  out  1  vehicle 1 starvation flag
aclik2  out  1  vehicle 2 starvation flag
durum  out  2  FSM state: 0=BOS, 1=TEK, 2=CIFT, 3=ARA

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset: state BOS, izin1=izin2=0, pulse=0, aclik=0, wait counters=0, window/guard counters=0, priority pointer=vehicle 1.
- Conflict function c(yon1, yon2)=1 when (yon1, yon2) is one of: (00,11), (01,01), (11,11), (10,10). All other pairs are non-conflicting.
- BOS state, evaluated each cycle on sampled inputs:
  - No request: stay in BOS.
  - One request: go to TEK and grant the requester.
  - Both requests, c=0: go to CIFT and grant both.
  - Both requests, c=1: go to TEK. Grant the vehicle with the starvation flag set. If neither or both flags are set, grant the pointer vehicle. Pulse carpisma_engellendi for one cycle together with the grant. Toggle the pointer to the other vehicle.
- Latency: izin rises on the clock edge after the request is sampled in BOS (1 cycle).
- Window:
  - The counter loads HAREKET_CYC-1 on entry to TEK or CIFT. izin holds while the counter is nonzero, so izin is high for exactly HAREKET_CYC cycles if the request is held.
  - Early drop: a granted vehicle dropping istek clears its izin on the next edge.
  - The window ends when the counter reaches 0 or all granted requests have dropped.
  - A request that arrives mid-window is not admitted; it waits for BOS.
- ARA state: entered at window end and lasts ARA_CYC cycles with no grants, then goes to BOS. If ARA_CYC=0, the window end goes straight to BOS.
- Direction changes during a window are ignored. Conflict is evaluated only in BOS.
- Starvation:
  - Per-vehicle wait counter increments while istek=1 and izin=0, saturating at MAX_BEKLE.
  - The counter clears when istek=0 or izin=1.
  - aclik = (counter == MAX_BEKLE), registered.
- rst mid-window: grants drop on that edge, and the block returns to the reset state.

Optional Feature:
- Macro CARPISMA_SAYAC_EN.
- Defined: adds output carpisma_sayisi (16 bits). It increments on every carpisma_engellendi pulse, saturates at 16'hFFFF, and clears on rst.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. Reset: assert rst 2 cycles with random inputs -> izin1=izin2=0, carpisma_engellendi=0, aclik=0, durum=0 throughout.
2. Non-conflict pair: HAREKET_CYC=4, ARA_CYC=1, istek1=istek2=1, yon1=00, yon2=10 sampled at cycle 0 -> izin1=izin2=1 cycles 1-4, durum=2, durum=3 at cycle 5, BOS at cycle 6, no pulse.
3. Conflict pair: yon1=01, yon2=01, both requests held, pointer=1 -> izin1 cycles 1-4 with pulse at cycle 1, ARA at 5, izin2 cycles 7-10 with a second pulse at 7 only if vehicle 1 still requests with a conflicting direction.
4. Early drop: single request istek1, drop at cycle 2 -> izin1 low from cycle 3, ARA at 3, BOS at 4.
5. Starvation priority: MAX_BEKLE=3, conflicting directions, vehicle 2 waiting through one window with pointer forced back to 1 -> aclik2=1 before the next BOS arbitration, vehicle 2 granted, aclik2 clears the cycle after izin2 rises.
6. Reset mid-window and optional counter: rst at cycle 2 of a window -> izin low at cycle 3, durum=0. With CARPISMA_SAYAC_EN defined, 3 serialised conflicts -> carpisma_sayisi=3, and 0 after rst.

Source files
------------

// File: rtl/arac_hareket_hakem.sv
// arac_hareket_hakem: two-vehicle lane arbiter with collision serialisation, round-robin and starvation flags
//   Ports: clk, rst (sync, active-high); istek1/istek2 move requests; yon1/yon2 directions {solbit, sagbit};
//   izin1/izin2 grants; carpisma_engellendi one-cycle serialisation pulse; aclik1/aclik2 starvation flags;
//   durum state (0=BOS 1=TEK 2=CIFT 3=ARA); carpisma_sayisi saturating pulse count when CARPISMA_SAYAC_EN is defined.
module arac_hareket_hakem #(
  parameter int HAREKET_CYC = 4,
  parameter int ARA_CYC     = 1,
  parameter int MAX_BEKLE   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       istek1,
  input  logic       istek2,
  input  logic [1:0] yon1,
  input  logic [1:0] yon2,
  output logic       izin1,
  output logic       izin2,
  output logic       carpisma_engellendi,
  output logic       aclik1,
  output logic       aclik2,
  output logic [1:0] durum
`ifdef CARPISMA_SAYAC_EN
  ,
  output logic [15:0] carpisma_sayisi
`endif
);
  typedef enum logic [1:0] {BOS, TEK, CIFT, ARA} durum_t;
  durum_t st;
  logic [15:0] cnt, gcnt, bekle1, bekle2, bekle1_n, bekle2_n;
  logic ptr2, carp, kazanan2, bitti;
  assign durum = st;
  always_comb begin
    carp = (yon1 == 2'b00 && yon2 == 2'b11) || (yon1 == yon2 && yon1 != 2'b00);
    // a single starving vehicle overrides the round-robin pointer
    kazanan2 = (aclik1 != aclik2) ? aclik2 : ptr2;
    bitti = (cnt == 16'd0) || !((izin1 && istek1) || (izin2 && istek2));
    bekle1_n = (!istek1 || izin1) ? 16'd0 : (bekle1 == 16'(MAX_BEKLE)) ? bekle1 : bekle1 + 16'd1;
    bekle2_n = (!istek2 || izin2) ? 16'd0 : (bekle2 == 16'(MAX_BEKLE)) ? bekle2 : bekle2 + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= BOS;
      izin1 <= 1'b0;
      izin2 <= 1'b0;
      carpisma_engellendi <= 1'b0;
      aclik1 <= 1'b0;
      aclik2 <= 1'b0;
      bekle1 <= 16'd0;
      bekle2 <= 16'd0;
      cnt <= 16'd0;
      gcnt <= 16'd0;
      ptr2 <= 1'b0;
`ifdef CARPISMA_SAYAC_EN
      carpisma_sayisi <= 16'd0;
`endif
    end else begin
      carpisma_engellendi <= 1'b0;
      bekle1 <= bekle1_n;
      bekle2 <= bekle2_n;
      aclik1 <= bekle1_n == 16'(MAX_BEKLE);
      aclik2 <= bekle2_n == 16'(MAX_BEKLE);
      case (st)
        BOS: begin
          if (istek1 && istek2 && carp) begin
            st <= TEK;
            izin1 <= !kazanan2;
            izin2 <= kazanan2;
            carpisma_engellendi <= 1'b1;
            ptr2 <= !ptr2;
            cnt <= 16'(HAREKET_CYC - 1);
`ifdef CARPISMA_SAYAC_EN
            carpisma_sayisi <= carpisma_sayisi + {15'd0, carpisma_sayisi != 16'hFFFF};
`endif
          end else if (istek1 || istek2) begin
            st <= (istek1 && istek2) ? CIFT : TEK;
            izin1 <= istek1;
            izin2 <= istek2;
            cnt <= 16'(HAREKET_CYC - 1);
          end
        end
        TEK, CIFT: begin
          if (bitti) begin
            izin1 <= 1'b0;
            izin2 <= 1'b0;
            st <= (ARA_CYC == 0) ? BOS : ARA;
            gcnt <= 16'(ARA_CYC - 1);
          end else begin
            cnt <= cnt - 16'd1;
            izin1 <= izin1 && istek1;
            izin2 <= izin2 && istek2;
          end
        end
        ARA: begin
          if (gcnt == 16'd0) st <= BOS;
          else gcnt <= gcnt - 16'd1;
        end
        default: st <= BOS;
      endcase
    end
  end
endmodule
